// File: rtl/key_lookup_arb_reli_tx.sv
// key_lookup_arb_reli_tx
// Shares one reli_tx key lookup table between NUM_REQ key producers
// (req 0 = NACK path, req 1 = DAT path). Key requests are arbitrated into a
// single registered key stream. An ID FIFO remembers which requester issued
// each key, so in-order lookup results can be routed back to that requester.
// Optional build macro: KEY_ARB_STRICT_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module key_lookup_arb_reli_tx #(
    parameter int NUM_REQ         = 2,
    parameter int KEY_WIDTH       = 133,
    parameter int RESULT_WIDTH    = 64,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*KEY_WIDTH-1:0] s_req_key_info,
    input  logic [NUM_REQ-1:0]           s_req_key_valid,
    output logic [NUM_REQ-1:0]           s_req_key_ready,
    output logic [KEY_WIDTH-1:0]         m_key_info,
    output logic                         m_key_valid,
    input  logic                         m_key_ready,
    input  logic [RESULT_WIDTH-1:0]      s_rsp_info,
    input  logic                         s_rsp_valid,
    output logic                         s_rsp_ready,
    output logic [RESULT_WIDTH-1:0]      m_rsp_info,
    output logic [NUM_REQ-1:0]           m_rsp_valid,
    input  logic [NUM_REQ-1:0]           m_rsp_ready,
    output logic [CNT_W-1:0]             outstanding_cnt,
    output logic                         err_unexp_rsp
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    // Key output register
    logic                 m_key_valid_q, m_key_valid_d;
    logic [KEY_WIDTH-1:0] m_key_info_q, m_key_info_d;

    // Arbitration pointer (next requester to be favoured)
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    // ID FIFO: requester index per key in flight, in issue order
    logic [ID_W-1:0]      id_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [KEY_WIDTH-1:0] req_key  [NUM_REQ];
    logic [ID_W-1:0]      scan_idx [NUM_REQ];
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic                 can_load;
    logic                 credit_ok;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [ID_W-1:0]      head_id;

    // Unpack the per-requester keys and the scan order starting at the pointer
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_key[gi]  = s_req_key_info[gi*KEY_WIDTH +: KEY_WIDTH];
            assign scan_idx[gi] = ID_W'((int'(rr_ptr_q) + gi) % NUM_REQ);
        end
    endgenerate

    // Pick the first valid requester in scan order
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && s_req_key_valid[scan_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    assign can_load   = !m_key_valid_q || m_key_ready;
    assign credit_ok  = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = id_mem_q[rd_ptr_q];

    // No grant while reset is asserted so nothing handshakes during reset
    assign push            = rst_n && can_load && credit_ok && grant_found;
    assign s_req_key_ready = push ? (NUM_REQ'(1) << grant_idx) : '0;

    // Route results to the requester at the FIFO head; drain strays when empty
    always_comb begin
        m_rsp_info  = s_rsp_info;
        m_rsp_valid = '0;
        s_rsp_ready = 1'b1;
        if (!fifo_empty) begin
            m_rsp_valid = s_rsp_valid ? (NUM_REQ'(1) << head_id) : '0;
            s_rsp_ready = m_rsp_ready[head_id];
        end
    end

    assign pop = !fifo_empty && s_rsp_valid && s_rsp_ready;

    // Next-state for key register, pointers, credit counter and error flag
    always_comb begin
        m_key_valid_d = m_key_valid_q;
        m_key_info_d  = m_key_info_q;
        rr_ptr_d      = rr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;

        if (push) begin
            m_key_valid_d = 1'b1;
            m_key_info_d  = req_key[grant_idx];
            wr_ptr_d      = wr_ptr_q + 1'b1;
`ifdef KEY_ARB_STRICT_PRIO_EN
            rr_ptr_d      = '0;
`else
            rr_ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
        end else if (m_key_ready) begin
            m_key_valid_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (fifo_empty && s_rsp_valid) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_key_valid_q <= 1'b0;
            m_key_info_q  <= '0;
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            m_key_valid_q <= m_key_valid_d;
            m_key_info_q  <= m_key_info_d;
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
        end
    end

    // ID storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign m_key_info      = m_key_info_q;
    assign m_key_valid     = m_key_valid_q;
    assign outstanding_cnt = cnt_q;
    assign err_unexp_rsp   = err_q;

endmodule
